mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_aludec.sv | 25 ++
 rtl/mc_controller.sv | 176 +++++++++++++++++
 tb/tb_mc_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// opcode and funct field values, ALU control codes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BLEEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12,
        LIWB    = 4'd13
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_known(input logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_J)    || (o == OP_BEQ) ||
               (o == OP_BLE)   || (o == OP_ADDI) || (o == OP_LI)  ||
               (o == OP_LW)    || (o == OP_SB)   || (o == OP_SW);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type funct decode: ALU operation and shift-amount operand select.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       shift
);

    // Unknown funct values fall back to add without shift.
    always_comb begin
        alucontrol = ALU_ADD;
        shift      = 1'b0;
        case (funct)
            F_ADD:   alucontrol = ALU_ADD;
            F_SUB:   alucontrol = ALU_SUB;
            F_AND:   alucontrol = ALU_AND;
            F_OR:    alucontrol = ALU_OR;
            F_SLT:   alucontrol = ALU_SLT;
            F_SLL:   shift      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore controller: sequences fetch/decode/execute/write-back and
// drives datapath selects and write enables from the current state.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       sign,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       shift,
    output logic       sb,
    output logic       li,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    mc_state_e state_q, state_d;
    logic      sb_q, sb_d;

    logic [2:0] rt_alu;
    logic       rt_shift;

    mc_aludec u_aludec (
        .funct      (funct),
        .alucontrol (rt_alu),
        .shift      (rt_shift)
    );

    // Next state; op is looked at only in DECODE and MEMADR. The byte-store
    // flag is captured in MEMADR so MEMWR does not depend on a later op.
    always_comb begin
        state_d = state_q;
        sb_d    = sb_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW, OP_SB: state_d = MEMADR;
                    OP_RTYPE:            state_d = RTYPEEX;
                    OP_BEQ:              state_d = BEQEX;
                    OP_BLE:              state_d = BLEEX;
                    OP_ADDI:             state_d = ADDIEX;
                    OP_J:                state_d = JEX;
                    OP_LI:               state_d = LIWB;
                    default:             state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
                sb_d    = (op == OP_SB);
            end
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
        end
    end

    logic ir_we, mem_we, reg_we, pc_we, done_raw, bad_raw;

    // Per-state output decode; write-type strobes are kept raw here and
    // qualified by reset below.
    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        shift      = 1'b0;
        sb         = 1'b0;
        li         = 1'b0;
        ir_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        done_raw   = 1'b0;
        bad_raw    = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                ir_we      = 1'b1;
                pc_we      = 1'b1;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                // An unknown opcode ends here, so it is also the last cycle.
                bad_raw    = !op_known(op);
                done_raw   = bad_raw;
            end
            MEMADR, ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                reg_we   = 1'b1;
                done_raw = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                mem_we   = 1'b1;
                sb       = sb_q;
                done_raw = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = rt_alu;
                shift      = rt_shift;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                reg_we   = 1'b1;
                done_raw = 1'b1;
            end
            ADDIWB, LIWB: begin
                li       = (state_q == LIWB);
                reg_we   = 1'b1;
                done_raw = 1'b1;
            end
            BEQEX, BLEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                done_raw   = 1'b1;
            end
            JEX: begin
                pcsrc    = 2'b10;
                pc_we    = 1'b1;
                done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    assign irwrite    = reset & ir_we;
    assign memwrite   = reset & mem_we;
    assign regwrite   = reset & reg_we;
    assign instr_done = reset & done_raw;
    assign illegal    = reset & bad_raw;
    assign pcen       = reset & (pc_we |
                                 ((state_q == BEQEX) & zero) |
                                 ((state_q == BLEEX) & (sign | zero)));
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes per-cycle expected
// outputs computed from the instruction's state sequence; a monitor pops and
// compares on every falling edge.
module tb_mc_controller;
    import mc_pkg::*;

    typedef struct packed {
        logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       pcen, shift, sb, li, instr_done, illegal;
        logic [3:0] state;
    } exp_t;

    localparam logic [5:0] B_R = 6'b000000, B_J = 6'b000010, B_BEQ = 6'b000100,
                           B_BLE = 6'b000110, B_ADDI = 6'b001000, B_LI = 6'b001111,
                           B_LW = 6'b100011, B_SB = 6'b101000, B_SW = 6'b101011;

    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, sign = 1'b0;
    logic iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic pcen, shift, sb, li, instr_done, illegal;
    logic [3:0] state;

    exp_t exp_q[$];
    int checks = 0, errors = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .shift(shift), .sb(sb),
        .li(li), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t sample();
        exp_t a;
        a.iord = iord; a.irwrite = irwrite; a.memwrite = memwrite; a.regwrite = regwrite;
        a.regdst = regdst; a.memtoreg = memtoreg; a.alusrca = alusrca; a.alusrcb = alusrcb;
        a.pcsrc = pcsrc; a.alucontrol = alucontrol; a.pcen = pcen; a.shift = shift;
        a.sb = sb; a.li = li; a.instr_done = instr_done; a.illegal = illegal; a.state = state;
        return a;
    endfunction

    function automatic logic legal(input logic [5:0] o);
        return o inside {B_R, B_J, B_BEQ, B_BLE, B_ADDI, B_LI, B_LW, B_SB, B_SW};
    endfunction

    // Expected outputs for one cycle, straight from the per-state table.
    function automatic exp_t model(input mc_state_e st, input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic s, input logic rst_low);
        exp_t e = '0;
        e.state = st;
        case (st)
            FETCH:   begin e.irwrite = 1; e.alusrcb = 2'b01; e.alucontrol = 3'b010; e.pcen = 1; end
            DECODE:  begin e.alusrcb = 2'b11; e.alucontrol = 3'b010;
                           e.illegal = !legal(o); e.instr_done = !legal(o); end
            MEMADR, ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
            MEMRD:   e.iord = 1;
            MEMWB:   begin e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1; end
            MEMWR:   begin e.iord = 1; e.memwrite = 1; e.sb = (o == B_SB); e.instr_done = 1; end
            RTYPEEX: begin
                e.alusrca = 1;
                e.shift = (f == 6'b000000);
                if (f == 6'b100010) e.alucontrol = 3'b110;
                else if (f == 6'b100100) e.alucontrol = 3'b000;
                else if (f == 6'b100101) e.alucontrol = 3'b001;
                else if (f == 6'b101010) e.alucontrol = 3'b111;
                else e.alucontrol = 3'b010;
            end
            RTYPEWB: begin e.regdst = 1; e.regwrite = 1; e.instr_done = 1; end
            ADDIWB:  begin e.regwrite = 1; e.instr_done = 1; end
            LIWB:    begin e.li = 1; e.regwrite = 1; e.instr_done = 1; end
            BEQEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                           e.pcen = z; e.instr_done = 1; end
            BLEEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                           e.pcen = s | z; e.instr_done = 1; end
            JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; e.instr_done = 1; end
            default: ;
        endcase
        if (rst_low) begin
            e.irwrite = 0; e.pcen = 0; e.memwrite = 0; e.regwrite = 0;
            e.instr_done = 0; e.illegal = 0;
        end
        return e;
    endfunction

    task automatic check(input string nm, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h (state got %0d want %0d)",
                     nm, $time, a, e, a.state, e.state);
        end
    endtask

    // Hold op only where it may be sampled and funct only in RTYPEEX;
    // everything else is scrambled to show it is ignored.
    task automatic drive(input mc_state_e st, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic s);
        op    = (st == DECODE || st == MEMADR) ? o : 6'($urandom);
        funct = (st == RTYPEEX) ? f : 6'($urandom);
        zero  = z;
        sign  = s;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        #1;
        check("reset_async", sample(), model(FETCH, op, funct, zero, sign, 1'b1));
        repeat (n) begin
            @(posedge clk); #1;
            drive(FETCH, 6'h0, 6'h0, 1'($urandom), 1'($urandom));
            exp_q.push_back(model(FETCH, op, funct, zero, sign, 1'b1));
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Issue one instruction. When 'first' is set the DUT is already in FETCH
    // for the current cycle. abort_idx >= 0 pulls reset during that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input logic s, input bit first, input int abort_idx,
                             output bit aborted);
        mc_state_e seq[$];
        aborted = 1'b0;
        seq.push_back(FETCH);
        seq.push_back(DECODE);
        case (o)
            B_LW:       begin seq.push_back(MEMADR); seq.push_back(MEMRD); seq.push_back(MEMWB); end
            B_SW, B_SB: begin seq.push_back(MEMADR); seq.push_back(MEMWR); end
            B_R:        begin seq.push_back(RTYPEEX); seq.push_back(RTYPEWB); end
            B_ADDI:     begin seq.push_back(ADDIEX); seq.push_back(ADDIWB); end
            B_BEQ:      seq.push_back(BEQEX);
            B_BLE:      seq.push_back(BLEEX);
            B_J:        seq.push_back(JEX);
            B_LI:       seq.push_back(LIWB);
            default:    ;
        endcase
        foreach (seq[i]) begin
            if (!(first && i == 0)) begin @(posedge clk); #1; end
            drive(seq[i], o, f, z, s);
            exp_q.push_back(model(seq[i], o, f, z, s, 1'b0));
            if (i == abort_idx) begin
                @(negedge clk); #2;
                do_reset(2);
                aborted = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: one comparison per falling edge while expectations are pending.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("cycle_st%0d", e.state), sample(), e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit ab;
        logic [5:0] ops [10];
        logic [5:0] fns [7];
        logic [5:0] o, f;
        int ai;
        ops = '{B_LW, B_SW, B_SB, B_R, B_BEQ, B_BLE, B_ADDI, B_J, B_LI, 6'h3f};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b010101};
        #3;
        do_reset(3);
        ab = 1'b1;
        // Directed cases.
        run_instr(B_LW,   6'h00, 0, 0, ab, -1, ab);
        run_instr(B_BEQ,  6'h00, 1, 0, ab, -1, ab);
        run_instr(B_BEQ,  6'h00, 0, 1, ab, -1, ab);
        run_instr(B_BLE,  6'h00, 0, 1, ab, -1, ab);
        run_instr(B_BLE,  6'h00, 1, 0, ab, -1, ab);
        run_instr(B_BLE,  6'h00, 0, 0, ab, -1, ab);
        run_instr(B_R,    6'b000000, 0, 0, ab, -1, ab);
        run_instr(B_R,    6'b101010, 0, 0, ab, -1, ab);
        run_instr(B_SB,   6'h00, 0, 0, ab, -1, ab);
        run_instr(B_SW,   6'h00, 0, 0, ab, -1, ab);
        run_instr(B_ADDI, 6'h00, 1, 1, ab, -1, ab);
        run_instr(B_J,    6'h00, 0, 0, ab, -1, ab);
        run_instr(B_LI,   6'h00, 0, 0, ab, -1, ab);
        run_instr(6'h3f,  6'h00, 0, 0, ab, -1, ab);
        run_instr(B_LW,   6'h00, 0, 0, ab, 3, ab);
        run_instr(B_ADDI, 6'h00, 0, 0, ab, -1, ab);
        // Randomized traffic with occasional mid-instruction resets.
        for (int n = 0; n < 250; n++) begin
            ai = $urandom_range(0, 9);
            o  = (ai == 9) ? 6'($urandom) : ops[ai];
            ai = $urandom_range(0, 6);
            f  = (ai == 6) ? 6'($urandom) : fns[ai];
            ai = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, f, 1'($urandom), 1'($urandom), ab, ai, ab);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
